// File: rtl/kgp_pkg.sv
// rtl/kgp_pkg.sv - shared branch-class encodings, sequencer states and PC defaults
package kgp_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_JLABEL = 2'd1,
    BR_BCOND  = 2'd2,
    BR_JREG   = 2'd3
  } br_type_e;

  typedef enum logic [2:0] {
    RESET_S = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    UPDATE  = 3'd4,
    HALT    = 3'd5
  } seq_state_e;

  // Branch-unit control bundle, in output order
  typedef struct packed {
    logic lbl_sel;
    logic jump_addr;
    logic branch;
    logic valid_jump;
  } br_ctrl_t;

  // Maps a decoded branch class (and ALU condition) to branch-unit controls
  function automatic br_ctrl_t br_ctrl(input br_type_e bt, input logic cond);
    br_ctrl_t c;
    c = '0;
    case (bt)
      BR_JLABEL: begin c.branch = 1'b1; c.valid_jump = 1'b1; end
      BR_BCOND:  begin c.lbl_sel = 1'b1; c.branch = 1'b1; c.valid_jump = cond; end
      BR_JREG:   begin c.jump_addr = 1'b1; c.branch = 1'b1; c.valid_jump = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/execute controller owning the PC
module pc_sequencer
  import kgp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic [1:0]  br_type,
  input  logic        cond_true,
  input  logic        exec_done,
  input  logic        halt,
  output logic [31:0] pc_inc,
  output logic        lbl_sel,
  output logic        jump_addr,
  output logic        branch,
  output logic        valid_jump,
  input  logic [31:0] bu_pc_new,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  br_type_e    br_type_q, br_type_d;
  br_ctrl_t    ctrl_q, ctrl_d;
  logic        taken_q, taken_d;

  assign pc_inc      = pc_q + PC_STEP;
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign retired     = retired_q;
  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == DECODE);
  assign halted      = (state_q == HALT);
  assign lbl_sel     = ctrl_q.lbl_sel;
  assign jump_addr   = ctrl_q.jump_addr;
  assign branch      = ctrl_q.branch;
  assign valid_jump  = ctrl_q.valid_jump;

  // Next state and datapath updates for the fetch/decode/exec/update loop
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    br_type_d = br_type_q;
    ctrl_d    = ctrl_q;
    taken_d   = taken_q;
    case (state_q)
      RESET_S: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        br_type_d = br_type_e'(br_type);
        ctrl_d    = br_ctrl(br_type_e'(br_type), cond_true);
        state_d   = EXEC;
      end
      EXEC: begin
        // A conditional branch keeps tracking the ALU flags until execute finishes
        if (br_type_q == BR_BCOND) begin
          ctrl_d.valid_jump = cond_true;
        end
        if (exec_done) begin
          taken_d = ctrl_d.branch & ctrl_d.valid_jump;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        pc_d      = taken_q ? bu_pc_new : pc_inc;
        retired_d = retired_q + 32'd1;
        ctrl_d    = '0;
        taken_d   = 1'b0;
        state_d   = halt ? HALT : FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = RESET_S;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_S;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      br_type_q <= BR_NONE;
      ctrl_q    <= '0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      br_type_q <= br_type_d;
      ctrl_q    <= ctrl_d;
      taken_q   <= taken_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [1:0]  br_type = 2'd0;
  logic        cond_true = 1'b0;
  logic        exec_done = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] pc_inc;
  logic        lbl_sel;
  logic        jump_addr;
  logic        branch;
  logic        valid_jump;
  logic [31:0] bu_pc_new = 32'd0;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halted;

  logic [3:0]  ctrl;
  logic [31:0] exp_retired = 32'd0;
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          pulse_cyc[$];

  assign ctrl = {lbl_sel, jump_addr, branch, valid_jump};

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .br_type    (br_type),
    .cond_true  (cond_true),
    .exec_done  (exec_done),
    .halt       (halt),
    .pc_inc     (pc_inc),
    .lbl_sel    (lbl_sel),
    .jump_addr  (jump_addr),
    .branch     (branch),
    .valid_jump (valid_jump),
    .bu_pc_new  (bu_pc_new),
    .pc         (pc),
    .retired    (retired),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (instr_valid === 1'b1) pulse_cyc.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting from a FETCH sample point and ending at the next state
  task automatic do_instr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] bt, input logic cnd, input logic [31:0] tgt,
                          input int ack_dly, input int exec_dly, input logic [3:0] exp_ctrl,
                          input logic [31:0] exp_next, input logic exp_halt);
    check({tag, ".fetch_addr"}, imem_addr, addr);
    check({tag, ".pc_inc"}, pc_inc, addr + 32'd4);
    br_type   = bt;
    cond_true = cnd;
    bu_pc_new = tgt;
    for (int i = 0; i < ack_dly; i++) begin
      step();
      check({tag, ".req_held"}, 32'(imem_req), 32'd1);
    end
    imem_ack  = 1'b1;
    imem_data = data;
    step();
    imem_ack  = 1'b0;
    imem_data = $urandom();
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'd1);
    check({tag, ".instr"}, instr, data);
    check({tag, ".dec_ctrl"}, 32'(ctrl), 32'd0);
    step();
    br_type = bt ^ 2'b11;
    check({tag, ".iv_once"}, 32'(instr_valid), 32'd0);
    check({tag, ".exec_ctrl"}, 32'(ctrl), 32'(exp_ctrl));
    for (int i = 0; i < exec_dly; i++) begin
      step();
      check({tag, ".exec_hold"}, 32'(ctrl), 32'(exp_ctrl));
    end
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    check({tag, ".upd_ctrl"}, 32'(ctrl), 32'(exp_ctrl));
    check({tag, ".upd_req"}, 32'(imem_req), 32'd0);
    exp_retired = exp_retired + 32'd1;
    step();
    check({tag, ".next_pc"}, pc, exp_next);
    check({tag, ".retired"}, retired, exp_retired);
    check({tag, ".post_ctrl"}, 32'(ctrl), 32'd0);
    check({tag, ".halted"}, 32'(halted), 32'(exp_halt));
    check({tag, ".req"}, 32'(imem_req), 32'(!exp_halt));
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    check("rst.pc", pc, 32'd0);
    check("rst.retired", retired, 32'd0);
    check("rst.instr", instr, 32'd0);
    check("rst.req", 32'(imem_req), 32'd0);
    check("rst.ctrl", 32'(ctrl), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    check("reset_s.req", 32'(imem_req), 32'd0);
    step();

    // Three sequential instructions with minimal latency
    do_instr("none0", 32'd0, 32'h1111_0000, 2'd0, 1'b0, 32'd0, 0, 0, 4'b0000, 32'd4, 1'b0);
    do_instr("none1", 32'd4, 32'h1111_0004, 2'd0, 1'b0, 32'd0, 0, 0, 4'b0000, 32'd8, 1'b0);
    do_instr("none2", 32'd8, 32'h1111_0008, 2'd0, 1'b0, 32'd0, 0, 0, 4'b0000, 32'd12, 1'b0);
    check("none.retired3", retired, 32'd3);
    check("none.pulses", 32'(pulse_cyc.size()), 32'd3);
    // FETCH, DECODE, EXEC, UPDATE between consecutive decode pulses
    check("none.gap01", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd4);
    check("none.gap12", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd4);

    // Jumps and conditional branches
    do_instr("jl_to200", 32'd12, 32'h2222_0000, 2'd1, 1'b0, 32'd200, 0, 0, 4'b0011, 32'd200, 1'b0);
    do_instr("jl_600", 32'd200, 32'h2222_0001, 2'd1, 1'b0, 32'd600, 0, 1, 4'b0011, 32'd600, 1'b0);
    do_instr("jl_back", 32'd600, 32'h2222_0002, 2'd1, 1'b1, 32'd200, 0, 0, 4'b0011, 32'd200, 1'b0);
    do_instr("bc_nt", 32'd200, 32'h3333_0000, 2'd2, 1'b0, 32'd404, 0, 0, 4'b1010, 32'd204, 1'b0);
    do_instr("jl_ret", 32'd204, 32'h2222_0003, 2'd1, 1'b0, 32'd200, 0, 0, 4'b0011, 32'd200, 1'b0);
    do_instr("bc_t", 32'd200, 32'h3333_0001, 2'd2, 1'b1, 32'd404, 0, 0, 4'b1011, 32'd404, 1'b0);
    do_instr("jreg", 32'd404, 32'h4444_0000, 2'd3, 1'b0, 32'd400, 3, 2, 4'b0111, 32'd400, 1'b0);

    // PC increment wraps at the top of the address space
    do_instr("jl_top", 32'd400, 32'h2222_0004, 2'd1, 1'b0, 32'hFFFF_FFFC, 0, 0, 4'b0011,
             32'hFFFF_FFFC, 1'b0);
    do_instr("wrap", 32'hFFFF_FFFC, 32'h5555_0000, 2'd0, 1'b1, 32'h1234_5678, 0, 0, 4'b0000,
             32'd0, 1'b0);
    do_instr("after_wrap", 32'd0, 32'h5555_0001, 2'd0, 1'b0, 32'd0, 0, 0, 4'b0000, 32'd4, 1'b0);

    // Asynchronous reset in the middle of EXEC
    check("rstx.addr", imem_addr, 32'd4);
    br_type   = 2'd3;
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    step();
    check("rstx.pre_ctrl", 32'(ctrl), 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstx.ctrl", 32'(ctrl), 32'd0);
    check("rstx.pc", pc, 32'd0);
    check("rstx.retired", retired, 32'd0);
    check("rstx.instr", instr, 32'd0);
    check("rstx.req", 32'(imem_req), 32'd0);
    check("rstx.halted", 32'(halted), 32'd0);
    exp_retired = 32'd0;
    exec_done   = 1'b1;
    imem_ack    = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    check("rstx.reset_s_req", 32'(imem_req), 32'd0);
    step();
    check("rstx.refetch_req", 32'(imem_req), 32'd1);
    check("rstx.refetch_addr", imem_addr, 32'd0);
    check("rstx.ack_ignored", instr, 32'd0);
    check("rstx.exec_ignored", retired, 32'd0);
    imem_ack  = 1'b0;
    exec_done = 1'b0;

    // Retired counter wraps on the halting instruction
    force dut.retired_q = 32'hFFFF_FFFF;
    step();
    release dut.retired_q;
    check("halt.preload", retired, 32'hFFFF_FFFF);
    exp_retired = 32'hFFFF_FFFF;
    halt = 1'b1;
    do_instr("halt", 32'd0, 32'h6666_0000, 2'd0, 1'b0, 32'd0, 0, 0, 4'b0000, 32'd4, 1'b1);
    check("halt.retired_wrap", retired, 32'd0);
    imem_ack  = 1'b1;
    exec_done = 1'b1;
    halt      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt.req_idle", 32'(imem_req), 32'd0);
      check("halt.stuck", 32'(halted), 32'd1);
    end
    check("halt.pc_frozen", pc, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
